// File: rtl/intf_mem_ctrl_pkg.sv
// Shared constants for the host-link memory controller: opcodes, FSM states
// and memory transfer length codes.
package intf_mem_ctrl_pkg;

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
  localparam logic [7:0] OP_RUN   = 8'h03;
  localparam logic [7:0] OP_HALT  = 8'h04;

  localparam logic [1:0] LEN_NONE = 2'b00;
  localparam logic [1:0] LEN_BYTE = 2'b01;
  localparam logic [1:0] LEN_HALF = 2'b10;
  localparam logic [1:0] LEN_WORD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_WRITE,
    ST_READ,
    ST_RD_WAIT,
    ST_TX
  } state_t;

  // Number of bytes moved by a given length code.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    logic [2:0] n;
    n = 3'd0;
    case (len)
      LEN_NONE: n = 3'd0;
      LEN_BYTE: n = 3'd1;
      LEN_HALF: n = 3'd2;
      LEN_WORD: n = 3'd4;
      default:  n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/intf_mem_ctrl.sv
// Byte-serial host link to data-memory bridge: decodes WRITE/READ/RUN/HALT
// commands, drives one-word memory accesses and streams read data back.
//
// state      | meaning
// IDLE       | waiting for an opcode byte
// ADDR       | collecting 4 address bytes, MSB first
// DATA       | collecting 4 write-data bytes, MSB first
// WRITE      | single-cycle memory write strobe
// READ       | single-cycle memory read request
// RD_WAIT    | memory read latency; data captured at end of cycle
// TX         | returning 4 read bytes, MSB first
module intf_mem_ctrl
  import intf_mem_ctrl_pkg::*;
#(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                rx_data,
  input  logic                      rx_valid,
  output logic                      rx_ready,
  output logic [7:0]                tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      mem_en,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [ADDRESS_LENGTH-1:0] mem_address,
  output logic [DATA_LENGTH-1:0]    mem_data_in,
  output logic [1:0]                mem_data_length,
  input  logic [DATA_LENGTH-1:0]    mem_data_out,
  output logic                      core_select,
  output logic                      busy,
  output logic                      cmd_err
);

  state_t                    r_state;
  logic [1:0]                r_cnt;
  logic                      r_is_write;
  logic [31:0]               r_tx_shift;
  logic [7:0]                r_tx_data;
  logic                      r_tx_valid;
  logic                      r_rx_ready;
  logic                      r_mem_en;
  logic                      r_mem_wr_en;
  logic                      r_mem_rd_en;
  logic [ADDRESS_LENGTH-1:0] r_mem_address;
  logic [DATA_LENGTH-1:0]    r_mem_data_in;
  logic [1:0]                r_mem_len;
  logic                      r_core_select;
  logic                      r_busy;
  logic                      r_cmd_err;

  logic        w_rx_fire;
  logic        w_tx_fire;
  logic [31:0] w_rd_word;

  assign w_rx_fire = rx_valid & r_rx_ready;
  assign w_tx_fire = r_tx_valid & tx_ready;
  assign w_rd_word = 32'(mem_data_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 2'd0;
      r_is_write    <= 1'b0;
      r_tx_shift    <= '0;
      r_tx_data     <= '0;
      r_tx_valid    <= 1'b0;
      r_rx_ready    <= 1'b0;
      r_mem_en      <= 1'b0;
      r_mem_wr_en   <= 1'b0;
      r_mem_rd_en   <= 1'b0;
      r_mem_address <= '0;
      r_mem_data_in <= '0;
      r_mem_len     <= LEN_NONE;
      r_core_select <= 1'b0;
      r_busy        <= 1'b0;
      r_cmd_err     <= 1'b0;
    end else begin
      r_cmd_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // Also raises rx_ready on the first cycle out of reset.
          r_rx_ready <= 1'b1;
          if (w_rx_fire) begin
            case (rx_data)
              OP_WRITE, OP_READ: begin
                if (r_core_select) begin
                  r_cmd_err <= 1'b1;
                end else begin
                  r_state    <= ST_ADDR;
                  r_cnt      <= 2'd0;
                  r_is_write <= (rx_data == OP_WRITE);
                  r_busy     <= 1'b1;
                end
              end
              OP_RUN:  r_core_select <= 1'b1;
              OP_HALT: r_core_select <= 1'b0;
              default: r_cmd_err     <= 1'b1;
            endcase
          end
        end
        ST_ADDR: begin
          if (w_rx_fire) begin
            r_mem_address <= {r_mem_address[ADDRESS_LENGTH-9:0], rx_data};
            r_cnt         <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              if (r_is_write) begin
                r_state <= ST_DATA;
              end else begin
                r_state     <= ST_READ;
                r_rx_ready  <= 1'b0;
                r_mem_en    <= 1'b1;
                r_mem_rd_en <= 1'b1;
                r_mem_len   <= LEN_NONE;
              end
            end
          end
        end
        ST_DATA: begin
          if (w_rx_fire) begin
            r_mem_data_in <= {r_mem_data_in[DATA_LENGTH-9:0], rx_data};
            r_cnt         <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state     <= ST_WRITE;
              r_rx_ready  <= 1'b0;
              r_mem_en    <= 1'b1;
              r_mem_wr_en <= 1'b1;
              r_mem_len   <= LEN_WORD;
            end
          end
        end
        ST_WRITE: begin
          r_state     <= ST_IDLE;
          r_mem_en    <= 1'b0;
          r_mem_wr_en <= 1'b0;
          r_mem_len   <= LEN_NONE;
          r_rx_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
        ST_READ: begin
          r_state  <= ST_RD_WAIT;
          r_mem_en <= 1'b0;
        end
        ST_RD_WAIT: begin
          // Top byte goes straight to tx_data; the rest waits in the shifter.
          r_state     <= ST_TX;
          r_mem_rd_en <= 1'b0;
          r_tx_data   <= w_rd_word[31:24];
          r_tx_shift  <= {w_rd_word[23:0], 8'h00};
          r_tx_valid  <= 1'b1;
          r_cnt       <= 2'd0;
        end
        ST_TX: begin
          if (w_tx_fire) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state    <= ST_IDLE;
              r_tx_valid <= 1'b0;
              r_tx_data  <= 8'h00;
              r_rx_ready <= 1'b1;
              r_busy     <= 1'b0;
            end else begin
              r_tx_data  <= r_tx_shift[31:24];
              r_tx_shift <= {r_tx_shift[23:0], 8'h00};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign rx_ready        = r_rx_ready;
  assign tx_data         = r_tx_data;
  assign tx_valid        = r_tx_valid;
  assign mem_en          = r_mem_en;
  assign mem_wr_en       = r_mem_wr_en;
  assign mem_rd_en       = r_mem_rd_en;
  assign mem_address     = r_mem_address;
  assign mem_data_in     = r_mem_data_in;
  assign mem_data_length = r_mem_len;
  assign core_select     = r_core_select;
  assign busy            = r_busy;
  assign cmd_err         = r_cmd_err;

endmodule

// File: tb/tb_intf_mem_ctrl.sv
// Directed bench for intf_mem_ctrl: host commands in, memory accesses and
// read-back bytes checked against scoreboard queues.
module tb_intf_mem_ctrl;
  import intf_mem_ctrl_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        mem_en;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [31:0] mem_address;
  logic [31:0] mem_data_in;
  logic [1:0]  mem_data_length;
  logic [31:0] mem_data_out;
  logic        core_select;
  logic        busy;
  logic        cmd_err;

  intf_mem_ctrl #(.DATA_LENGTH(32), .ADDRESS_LENGTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .mem_en          (mem_en),
    .mem_wr_en       (mem_wr_en),
    .mem_rd_en       (mem_rd_en),
    .mem_address     (mem_address),
    .mem_data_in     (mem_data_in),
    .mem_data_length (mem_data_length),
    .mem_data_out    (mem_data_out),
    .core_select     (core_select),
    .busy            (busy),
    .cmd_err         (cmd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         q_wr[$];
  logic [31:0] q_rd[$];
  logic [7:0]  q_tx[$];

  int n_checks = 0;
  int n_errors = 0;
  int rd_cycles = 0;
  int wr_events = 0;
  int err_pulses = 0;
  int stall_cycles = 0;
  bit prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  logic [31:0] mem_model [logic [31:0]];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] all_outs();
    return {46'd0, rx_ready, tx_valid, tx_data, mem_en, mem_wr_en, mem_rd_en,
            mem_address, mem_data_in, mem_data_length, core_select, busy, cmd_err};
  endfunction

  // Data memory wrapper model: one-cycle registered read.
  always @(posedge clk) begin
    if (mem_en && mem_wr_en) mem_model[mem_address] = mem_data_in;
    if (mem_en && mem_rd_en)
      mem_data_out <= mem_model.exists(mem_address) ? mem_model[mem_address] : 32'h0;
  end

  // Output monitor / scoreboard consumer.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (mem_en && mem_wr_en) begin
        wr_t e;
        if (q_wr.size() != 0) e = q_wr.pop_front();
        else e = '{addr: 'x, data: 'x};
        chk("wr_addr", mem_address, e.addr);
        chk("wr_data", mem_data_in, e.data);
        chk("wr_len_bytes", len_bytes(mem_data_length), 4);
        wr_events++;
      end
      if (mem_en && mem_rd_en) begin
        logic [31:0] a;
        a = (q_rd.size() != 0) ? q_rd.pop_front() : 'x;
        chk("rd_addr", mem_address, a);
        chk("rd_len", mem_data_length, LEN_NONE);
      end
      if (mem_rd_en) rd_cycles++;
      if (cmd_err) err_pulses++;
      if (prev_stall) begin
        chk("tx_stall_valid", tx_valid, 1);
        chk("tx_stall_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        logic [7:0] b;
        b = (q_tx.size() != 0) ? q_tx.pop_front() : 'x;
        chk("tx_byte", tx_data, b);
      end
      prev_stall = tx_valid && !tx_ready;
      if (prev_stall) stall_cycles++;
      prev_data = tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("rx_ready_timeout", rx_ready, 1);
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic run_until_idle(input bit toggle, input string tag);
    int n = 0;
    while ((busy || q_tx.size() != 0) && n < 500) begin
      @(posedge clk);
      #1;
      if (toggle) tx_ready = ~tx_ready;
      n++;
    end
    chk(tag, (n < 500), 1);
    tx_ready = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    int w0;
    w0 = wr_events;
    q_wr.push_back('{addr: a, data: d});
    send_byte(OP_WRITE);
    send_word(a);
    send_word(d);
    run_until_idle(1'b0, "write_idle");
    chk("write_count", wr_events - w0, 1);
    chk("write_q_empty", q_wr.size(), 0);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] d, input bit toggle);
    int r0;
    r0 = rd_cycles;
    q_rd.push_back(a);
    q_tx.push_back(d[31:24]);
    q_tx.push_back(d[23:16]);
    q_tx.push_back(d[15:8]);
    q_tx.push_back(d[7:0]);
    send_byte(OP_READ);
    send_word(a);
    if (toggle) tx_ready = 1'b0;
    run_until_idle(toggle, "read_idle");
    chk("read_rd_en_cycles", rd_cycles - r0, 2);
    chk("read_tx_q_empty", q_tx.size(), 0);
    chk("read_rd_q_empty", q_rd.size(), 0);
  endtask

  initial begin
    int e0;
    int w0;
    int s0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_ready_at_release", rx_ready, 0);
    @(posedge clk);
    #1;
    chk("rx_ready_rise", rx_ready, 1);

    // Write then back-to-back read of the same word.
    do_write(32'h0000_0010, 32'hDEAD_BEEF);
    chk("addr_hold", mem_address, 32'h0000_0010);
    chk("data_hold", mem_data_in, 32'hDEAD_BEEF);
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

    // Second word, read back under tx backpressure.
    do_write(32'h0000_0020, 32'h1234_5678);
    s0 = stall_cycles;
    do_read(32'h0000_0020, 32'h1234_5678, 1'b1);
    chk("stalls_seen", (stall_cycles > s0), 1);
    chk("data_hold_after_read", mem_data_in, 32'h1234_5678);

    // Ownership: commands rejected while the core owns memory.
    send_byte(OP_RUN);
    chk("core_select_run", core_select, 1);
    e0 = err_pulses;
    w0 = wr_events;
    send_byte(OP_WRITE);
    repeat (3) @(negedge clk);
    chk("owned_write_err", err_pulses - e0, 1);
    chk("owned_write_no_mem", wr_events - w0, 0);
    chk("owned_write_idle", {busy, rx_ready}, 2'b01);
    @(posedge clk);
    #1;
    send_byte(OP_HALT);
    chk("core_select_halt", core_select, 0);
    do_read(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);

    // Unknown opcode.
    e0 = err_pulses;
    send_byte(8'h7F);
    repeat (3) @(negedge clk);
    chk("bad_op_err_pulse", err_pulses - e0, 1);
    chk("bad_op_idle", {busy, rx_ready, cmd_err}, 3'b010);
    @(posedge clk);
    #1;

    // Reset in the middle of a READ address phase.
    send_byte(OP_READ);
    send_byte(8'h00);
    send_byte(8'h00);
    chk("mid_read_busy", busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midop_reset_outputs", all_outs(), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rx_ready_after_midop", rx_ready, 1);
    do_write(32'h0000_0030, 32'hCAFE_F00D);
    do_read(32'h0000_0030, 32'hCAFE_F00D, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/intf_mem_ctrl.md
INTF_MEM_CTRL -- requirements
Module: intf_mem_ctrl

Interface
REQ-001 Parameter DATA_LENGTH, default 32: memory data width.
REQ-002 Parameter ADDRESS_LENGTH, default 32: memory address width; carries a word address.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rx_data  in  8  command/payload byte from the host link.
REQ-006 rx_valid  in  1  rx_data valid.
REQ-007 rx_ready  out  1  block accepts rx_data; a byte transfers when rx_valid & rx_ready.
REQ-008 tx_data  out  8  read-back byte to the host link.
REQ-009 tx_valid  out  1  tx_data valid.
REQ-010 tx_ready  in  1  link accepts tx_data; a byte transfers when tx_valid & tx_ready.
REQ-011 mem_en / mem_wr_en / mem_rd_en  out  1 each  memory port controls, interface side of the data memory wrapper.
REQ-012 mem_address  out  ADDRESS_LENGTH  word address.
REQ-013 mem_data_in  out  DATA_LENGTH  write data.
REQ-014 mem_data_length  out  2  length code: 00 none, 01 byte, 10 half, 11 word.
REQ-015 mem_data_out  in  DATA_LENGTH  read data returned by the wrapper.
REQ-016 core_select  out  1  1 = core owns memory; 0 = this block owns it.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 cmd_err  out  1  one-cycle pulse on a rejected command.

Function
REQ-019 Opcodes: 0x01 WRITE, 0x02 READ, 0x03 RUN (core_select<=1), 0x04 HALT (core_select<=0).
- RUN and HALT complete in IDLE.
- All other opcodes pulse cmd_err and stay in IDLE.
REQ-020 States:
- IDLE, ADDR, DATA, WRITE, READ, RD_WAIT, TX.
- A 2-bit byte counter serves ADDR, DATA and TX.
REQ-021 rx_ready is 1 only in IDLE, ADDR and DATA.
REQ-022 ADDR state: accepts 4 bytes, MSB first, into mem_address.
- After the 4th byte: WRITE opcode -> DATA; READ opcode -> READ.
REQ-023 DATA state: accepts 4 bytes, MSB first, into mem_data_in, then -> WRITE.
REQ-024 WRITE state: lasts exactly one cycle, the cycle after the last data byte is accepted.
- Drives mem_en=1, mem_wr_en=1, mem_data_length=11.
- Then -> IDLE.
REQ-025 READ state: one cycle, mem_en=1, mem_rd_en=1, mem_data_length=00.
REQ-026 RD_WAIT state: one cycle, mem_en=0, mem_rd_en=1.
- mem_data_out is captured into the tx shift register at the end of this cycle.
- Then -> TX.
REQ-027 TX state: sends 4 bytes MSB first.
- tx_data and tx_valid are held stable while tx_valid & !tx_ready.
- After the 4th accepted byte -> IDLE.
REQ-028 Outside the WRITE, READ and RD_WAIT states: mem_en, mem_wr_en and mem_rd_en are 0 and mem_data_length is 00.
REQ-029 WRITE or READ received while core_select=1: cmd_err pulses, no memory access occurs, state stays IDLE.
REQ-030 rx_valid held low mid-command: the block waits indefinitely; there is no timeout.
- tx_ready held low: TX waits indefinitely.
REQ-031 mem_address and mem_data_in hold their last values between commands.
REQ-032 Back-to-back commands: an opcode is accepted in the first IDLE cycle after a command completes.

Reset
REQ-033 While rst_n=0, and at any point mid-operation, the block returns to IDLE and drives:
- 0 on: rx_ready, tx_valid, tx_data, mem_en, mem_wr_en, mem_rd_en, mem_address, mem_data_in, mem_data_length, core_select, busy, cmd_err.
- Byte counter 0.
REQ-034 rx_ready rises in the first clk cycle after rst_n deasserts.

Structure
REQ-035 Package intf_mem_ctrl_pkg holds:
- opcode constants;
- state encoding;
- length codes LEN_NONE, LEN_BYTE, LEN_HALF, LEN_WORD.
REQ-036 Single module; no sub-module is required.

Verification
REQ-037 Write: send 01 00 00 00 10 DE AD BE EF.
- Exactly one cycle with mem_en=mem_wr_en=1, mem_address=0x10, mem_data_in=0xDEADBEEF, mem_data_length=11.
REQ-038 Read: send 02 00 00 00 10 with the memory model returning 0xDEADBEEF.
- tx bytes DE, AD, BE, EF in order.
- mem_rd_en high for exactly 2 cycles.
REQ-039 Backpressure: tx_ready toggled 0/1 every other cycle during a read.
- tx_data is stable while stalled; all 4 bytes are delivered once each.
REQ-040 Ownership: send 03, then 01 ..., then 04, then 02 00 00 00 10.
- core_select=1 after 03; the WRITE opcode pulses cmd_err and issues no mem_en; core_select=0 after 04; the read then completes.
REQ-041 Bad opcode and reset: send 0x7F.
- cmd_err pulses for 1 cycle and the block stays IDLE.
- rst_n pulsed low after the 2nd address byte of a READ: all outputs 0, then the next command executes normally.
